npu_tile_sequencer: RTL
=======================

Name: npu_tile_sequencer

Overview:
- Runtime-programmable tile/kernel loop sequencer for the W x W NPU array.
- Replaces compile-time per-layer tile constants with per-layer config latched at start, so one netlist runs every conv layer.
- Walks output-channel tiles, spatial tiles, input-channel tiles and kernel taps. Emits one address/control beat per accumulate step to the activation memory and PE array over a valid/ready handshake.

Parameters:
W, 8, PE array edge (pixels per tile side)
K, 5, kernel size; KK = K*K taps per tile pass
MAX_NB_TILE, 4, max spatial tiles per image side
MAX_NB_TILEB, 16, max input-channel tiles
MAX_NB_TILEC, 16, max output-channel tiles
ADDR_W, $clog2(MAX_NB_TILE*MAX_NB_TILE*MAX_NB_TILEB), activation memory word-address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle launch; sampled only in IDLE
cfg_nb_tile  in  $clog2(MAX_NB_TILE)+1  spatial tiles per side
cfg_nb_tileb  in  $clog2(MAX_NB_TILEB)+1  input-channel tiles
cfg_nb_tilec  in  $clog2(MAX_NB_TILEC)+1  output-channel tiles
busy  out  1  high in RUN and DONE
beat_valid  out  1  beat fields valid
beat_ready  in  1  consumer accepts beat
tile_r  out  $clog2(MAX_NB_TILE)  spatial tile row
tile_c  out  $clog2(MAX_NB_TILE)  spatial tile column
tileb  out  $clog2(MAX_NB_TILEB)  input-channel tile
tilec  out  $clog2(MAX_NB_TILEC)  output-channel tile
kk  out  $clog2(KK)  kernel tap 0..KK-1
mem_addr  out  ADDR_W  ((tile_r*nb_tile + tile_c)*nb_tileb + tileb)
first_acc  out  1  kk==0 && tileb==0 (clear accumulator)
last_acc  out  1  kk==KK-1 && tileb==nb_tileb-1 (write back output tile)
done  out  1  one-cycle completion pulse
cfg_err  out  1  one-cycle pulse with done when config is illegal

Behaviour:
- Reset: state=IDLE. All outputs and counters are 0. Latched config is 0.
- States:
  - IDLE: on start, latch cfg_*.
    - Illegal config (any field 0, or above its MAX) -> DONE with cfg_err.
    - Otherwise -> RUN with all counters 0.
  - RUN: beat_valid=1.
    - A beat is accepted on a cycle with beat_valid && beat_ready. Counters advance only on acceptance.
    - Loop nest, innermost first: kk, tileb, tile_c, tile_r, tilec. Each counter wraps to 0 at its bound (KK / nb_tileb / nb_tile / nb_tile / nb_tilec) and carries to the next.
    - Acceptance of the final beat (all counters at max) -> DONE.
  - DONE: one cycle. done=1, beat_valid=0, then -> IDLE.
- Latency: start accepted at cycle t gives first beat valid at t+1. With beat_ready tied high, one beat per cycle, no bubbles. done is asserted the cycle after the last acceptance.
- Total beats = nb_tilec * nb_tile^2 * nb_tileb * KK.
- Handshake: while beat_valid && !beat_ready, all beat fields hold stable. beat_valid never drops in RUN until the final acceptance.
- All beat fields, first_acc and last_acc are registered outputs with zero combinational path from beat_ready.
- mem_addr: computed in ADDR_W unsigned arithmetic from latched config. Valid for legal configs with no overflow by construction.
- start in RUN or DONE is ignored. cfg_* changes after latch have no effect.
- Async reset mid-RUN: immediate return to IDLE. beat_valid and done are 0. No done pulse.
- nb_tileb=1: first_acc and last_acc both assert on beats with kk==0 and kk==KK-1 respectively, for every tile.

Optional Feature:
NPU_SEQ_ABORT_EN
- Defined: adds input port abort (1 bit).
  - abort in RUN -> DONE next cycle, even if a beat is accepted that cycle. done pulses with cfg_err=0 and no further beats.
  - abort in IDLE or DONE is ignored. abort has priority over beat completion.
- Undefined: no abort port. The sequence always runs to completion.

Test Plan:
- Layer-1 config nb_tile=4, nb_tileb=1, nb_tilec=6, ready=1 -> 2400 beats on consecutive cycles. First beat at start+1. done at cycle after beat 2400. last_acc on every 25th beat. Final mem_addr=15.
- Layer-2 config 2/6/16, ready=1 -> 9600 beats. first_acc once per 150 beats. last_acc on beats 150k. mem_addr sequence per tile 0..5 repeated 25x each.
- Random beat_ready (50%) on layer-2 config -> fields stable while stalled. Beat count still 9600 and sequence identical to the ready=1 run.
- start with nb_tileb=0 or nb_tile=5 (MAX 4) -> no beat_valid. done and cfg_err high at start+1. busy high for exactly that cycle.
- start pulsed again mid-RUN, then rst_n low at beat 100 -> second start ignored. All outputs 0 immediately on reset. A new start after release runs cleanly from tile 0.
- NPU_SEQ_ABORT_EN: abort at beat 50 of layer-1 -> done next cycle, no beat 51, busy low the cycle after.

Source files
------------

// File: rtl/npu_tile_sequencer.sv
// -----------------------------------------------------------------------------
// npu_tile_sequencer
//
// Runtime-programmable tile/kernel loop sequencer for the W x W NPU array.
// A per-layer config is latched on start. The block then walks the loop
// nest, innermost first: kernel tap, input-channel tile, tile column,
// tile row, output-channel tile. It emits one address/control beat per
// accumulate step over a valid/ready handshake.
//
// Optional feature macro: NPU_SEQ_ABORT_EN (adds the 'abort' input).
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             single-cycle launch, sampled only in IDLE
//   cfg_nb_tile       spatial tiles per image side
//   cfg_nb_tileb      input-channel tiles
//   cfg_nb_tilec      output-channel tiles
//   busy              high in RUN and DONE
//   beat_valid        beat fields valid (RUN)
//   beat_ready        consumer accepts the current beat
//   abort             (NPU_SEQ_ABORT_EN only) cut the layer short
//   tile_r, tile_c    spatial tile row / column
//   tileb, tilec      input / output channel tile
//   kk                kernel tap 0..K*K-1
//   mem_addr          ((tile_r*nb_tile + tile_c)*nb_tileb + tileb)
//   first_acc         clear accumulator (kk==0 && tileb==0)
//   last_acc          write back output tile (kk==KK-1 && tileb==nb_tileb-1)
//   done              one-cycle completion pulse
//   cfg_err           one-cycle pulse alongside done for an illegal config
// -----------------------------------------------------------------------------
module npu_tile_sequencer #(
    parameter int W            = 8,
    parameter int K            = 5,
    parameter int MAX_NB_TILE  = 4,
    parameter int MAX_NB_TILEB = 16,
    parameter int MAX_NB_TILEC = 16,
    parameter int ADDR_W       = $clog2(MAX_NB_TILE*MAX_NB_TILE*MAX_NB_TILEB)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [$clog2(MAX_NB_TILE):0]      cfg_nb_tile,
    input  logic [$clog2(MAX_NB_TILEB):0]     cfg_nb_tileb,
    input  logic [$clog2(MAX_NB_TILEC):0]     cfg_nb_tilec,
    output logic                              busy,
    output logic                              beat_valid,
    input  logic                              beat_ready,
`ifdef NPU_SEQ_ABORT_EN
    input  logic                              abort,
`endif
    output logic [$clog2(MAX_NB_TILE)-1:0]    tile_r,
    output logic [$clog2(MAX_NB_TILE)-1:0]    tile_c,
    output logic [$clog2(MAX_NB_TILEB)-1:0]   tileb,
    output logic [$clog2(MAX_NB_TILEC)-1:0]   tilec,
    output logic [$clog2(K*K)-1:0]            kk,
    output logic [ADDR_W-1:0]                 mem_addr,
    output logic                              first_acc,
    output logic                              last_acc,
    output logic                              done,
    output logic                              cfg_err
);

    localparam int KK    = K * K;
    localparam int KK_W  = $clog2(KK);
    localparam int T_W   = $clog2(MAX_NB_TILE);
    localparam int TB_W  = $clog2(MAX_NB_TILEB);
    localparam int TC_W  = $clog2(MAX_NB_TILEC);
    localparam int CT_W  = T_W + 1;
    localparam int CB_W  = TB_W + 1;
    localparam int CC_W  = TC_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [CT_W-1:0]     nbt_q, nbt_d;
    logic [CB_W-1:0]     nbb_q, nbb_d;
    logic [CC_W-1:0]     nbc_q, nbc_d;
    logic                err_q, err_d;
    logic [KK_W-1:0]     kk_q, kk_d;
    logic [TB_W-1:0]     tileb_q, tileb_d;
    logic [T_W-1:0]      tile_c_q, tile_c_d;
    logic [T_W-1:0]      tile_r_q, tile_r_d;
    logic [TC_W-1:0]     tilec_q, tilec_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                first_q, first_d;
    logic                last_q, last_d;

    logic cfg_bad;
    logic kk_last, tileb_last, tile_c_last, tile_r_last, tilec_last;

    // An empty PE array cannot run any layer, so it is treated like a bad config.
    assign cfg_bad = (cfg_nb_tile  == '0) || (cfg_nb_tile  > CT_W'(MAX_NB_TILE))  ||
                     (cfg_nb_tileb == '0) || (cfg_nb_tileb > CB_W'(MAX_NB_TILEB)) ||
                     (cfg_nb_tilec == '0) || (cfg_nb_tilec > CC_W'(MAX_NB_TILEC)) ||
                     (W < 1);

    assign kk_last     = (kk_q == KK_W'(KK - 1));
    assign tileb_last  = ({1'b0, tileb_q}  == nbb_q - CB_W'(1));
    assign tile_c_last = ({1'b0, tile_c_q} == nbt_q - CT_W'(1));
    assign tile_r_last = ({1'b0, tile_r_q} == nbt_q - CT_W'(1));
    assign tilec_last  = ({1'b0, tilec_q}  == nbc_q - CC_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            nbt_q    <= '0;
            nbb_q    <= '0;
            nbc_q    <= '0;
            err_q    <= 1'b0;
            kk_q     <= '0;
            tileb_q  <= '0;
            tile_c_q <= '0;
            tile_r_q <= '0;
            tilec_q  <= '0;
            addr_q   <= '0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            nbt_q    <= nbt_d;
            nbb_q    <= nbb_d;
            nbc_q    <= nbc_d;
            err_q    <= err_d;
            kk_q     <= kk_d;
            tileb_q  <= tileb_d;
            tile_c_q <= tile_c_d;
            tile_r_q <= tile_r_d;
            tilec_q  <= tilec_d;
            addr_q   <= addr_d;
            first_q  <= first_d;
            last_q   <= last_d;
        end
    end

    // Next state and next beat. The beat fields are precomputed one cycle
    // ahead so that they leave the block straight from flops.
    always_comb begin
        state_d  = state_q;
        nbt_d    = nbt_q;
        nbb_d    = nbb_q;
        nbc_d    = nbc_q;
        err_d    = err_q;
        kk_d     = kk_q;
        tileb_d  = tileb_q;
        tile_c_d = tile_c_q;
        tile_r_d = tile_r_q;
        tilec_d  = tilec_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    nbt_d    = cfg_nb_tile;
                    nbb_d    = cfg_nb_tileb;
                    nbc_d    = cfg_nb_tilec;
                    err_d    = cfg_bad;
                    state_d  = cfg_bad ? S_DONE : S_RUN;
                    kk_d     = '0;
                    tileb_d  = '0;
                    tile_c_d = '0;
                    tile_r_d = '0;
                    tilec_d  = '0;
                end
            end
            S_RUN: begin
                if (beat_ready) begin
                    kk_d = kk_last ? '0 : kk_q + KK_W'(1);
                    if (kk_last) begin
                        tileb_d = tileb_last ? '0 : tileb_q + TB_W'(1);
                        if (tileb_last) begin
                            tile_c_d = tile_c_last ? '0 : tile_c_q + T_W'(1);
                            if (tile_c_last) begin
                                tile_r_d = tile_r_last ? '0 : tile_r_q + T_W'(1);
                                if (tile_r_last) begin
                                    tilec_d = tilec_last ? '0 : tilec_q + TC_W'(1);
                                    if (tilec_last) begin
                                        state_d = S_DONE;
                                    end
                                end
                            end
                        end
                    end
                end
`ifdef NPU_SEQ_ABORT_EN
                // Abort wins over whatever the accepted beat would have done.
                if (abort) begin
                    state_d = S_DONE;
                end
`endif
                // Counters are parked at zero outside RUN so idle outputs stay quiet.
                if (state_d == S_DONE) begin
                    kk_d     = '0;
                    tileb_d  = '0;
                    tile_c_d = '0;
                    tile_r_d = '0;
                    tilec_d  = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        addr_d  = ADDR_W'((ADDR_W'(tile_r_d) * ADDR_W'(nbt_d) + ADDR_W'(tile_c_d))
                          * ADDR_W'(nbb_d) + ADDR_W'(tileb_d));
        first_d = (state_d == S_RUN) && (kk_d == '0) && (tileb_d == '0);
        last_d  = (state_d == S_RUN) && (kk_d == KK_W'(KK - 1)) &&
                  ({1'b0, tileb_d} == nbb_d - CB_W'(1));
    end

    // Control outputs are decoded from the registered state only.
    always_comb begin
        busy       = (state_q != S_IDLE);
        beat_valid = (state_q == S_RUN);
        done       = (state_q == S_DONE);
        cfg_err    = (state_q == S_DONE) && err_q;
    end

    assign tile_r    = tile_r_q;
    assign tile_c    = tile_c_q;
    assign tileb     = tileb_q;
    assign tilec     = tilec_q;
    assign kk        = kk_q;
    assign mem_addr  = addr_q;
    assign first_acc = first_q;
    assign last_acc  = last_q;

endmodule
